// File: rtl/player_btn_conditioner.sv
// Purpose : turns four raw board buttons into clean one-hot move pulses with hold-to-repeat.
// Latency : 2-cycle synchronizer + DEBOUNCE_CYCLES debounce; move_pulse registers one cycle after btn_level rises.
// Backpressure: none; enable=0 suppresses pulses (debouncing continues), direction changes abort to IDLE.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   btns       raw buttons [0]=up [1]=down [2]=left [3]=right, 1=pressed
//   enable     game running; 0 suppresses move pulses
//   move_pulse registered one-hot (or zero) move command, same bit order as btns
//   btn_level  debounced button levels
//   repeating  high while auto-repeat is active
module player_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 30000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btns,
  input  logic       enable,
  output logic [3:0] move_pulse,
  output logic [3:0] btn_level,
  output logic       repeating
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int T_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TM_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] DELAY_LAST = TM_W'(REPEAT_DELAY - 1);
  localparam logic [TM_W-1:0] RATE_LAST  = TM_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [3:0]      syncMeta;
  logic [3:0]      syncOut;
  logic [DB_W-1:0] dbCnt [4];
  logic            selVld;
  logic [1:0]      sel;
  logic [1:0]      dir;
  logic [TM_W-1:0] timer;
  state_t          state;

  function automatic logic [3:0] oneHot(input logic [1:0] d);
    oneHot = 4'b0001 << d;
  endfunction

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncMeta <= '0;
      syncOut  <= '0;
    end else begin
      syncMeta <= btns;
      syncOut  <= syncMeta;
    end
  end

  // Per-bit debouncer: the level flips only after the synchronized input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_level <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (syncOut[i] == btn_level[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DB_LAST) begin
          btn_level[i] <= syncOut[i];
          dbCnt[i]     <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end
      end
    end
  end

  // Priority select: up > down > left > right.
  always_comb begin
    selVld = 1'b1;
    sel    = 2'd0;
    if (btn_level[0])      sel = 2'd0;
    else if (btn_level[1]) sel = 2'd1;
    else if (btn_level[2]) sel = 2'd2;
    else if (btn_level[3]) sel = 2'd3;
    else                   selVld = 1'b0;
  end

  // Pulse/repeat FSM. Any change of the selected direction (including release)
  // or loss of enable drops back to IDLE, which re-decides on the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dir        <= 2'd0;
      timer      <= '0;
      move_pulse <= '0;
      repeating  <= 1'b0;
    end else begin
      move_pulse <= '0;
      repeating  <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && selVld) begin
            move_pulse <= oneHot(sel);
            dir        <= sel;
            timer      <= '0;
            state      <= DELAY;
          end
        end
        DELAY: begin
          if (!enable || !selVld || sel != dir) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == DELAY_LAST) begin
            move_pulse <= oneHot(dir);
            timer      <= '0;
            repeating  <= 1'b1;
            state      <= REPEAT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!enable || !selVld || sel != dir) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            repeating <= 1'b1;
            if (timer == RATE_LAST) begin
              move_pulse <= oneHot(dir);
              timer      <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/player_btn_conditioner.md
Name: player_btn_conditioner

Overview:
- Sits directly upstream of the player object and turns the four raw board buttons into clean move commands for it.
- Synchronizes and debounces the buttons, then produces one-cycle move pulses with hold-to-repeat.
- Outputs drive the player object's btns input and its clock-domain move logic.
- Also reports debounced button levels and the repeat state.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronized input must differ from its debounced value before that value flips (10 ms at 100 MHz).
- REPEAT_DELAY, 30000000, clk cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_RATE, 10000000, clk cycles between subsequent auto-repeat pulses.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- btns  input  4  raw asynchronous buttons: [0]=up, [1]=down, [2]=left, [3]=right; 1=pressed.
- enable  input  1  game running; 0 suppresses move pulses.
- move_pulse  output  4  registered one-hot (or zero) move command; same bit order as btns.
- btn_level  output  4  debounced button levels.
- repeating  output  1  high while in REPEAT state.

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchronizer flops, debounced levels, counters, move_pulse, btn_level and repeating go to 0.
  - FSM goes to IDLE.
  - Outputs stay 0 until rst=1.
- Synchronizer:
  - Two flops per bit, 2-cycle latency.
  - Debouncer sees only the synchronized value sync[i].
- Debouncer, per bit, independent counter of width $clog2(DEBOUNCE_CYCLES):
  - sync[i]==btn_level[i]: counter cleared to 0.
  - Otherwise the counter increments.
  - Counter == DEBOUNCE_CYCLES-1 while still differing: btn_level[i] <= sync[i] and counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change btn_level.
- Direction select (combinational from btn_level): sel = highest-priority set bit, priority up > down > left > right; sel = none if btn_level == 0.
- FSM states IDLE, DELAY, REPEAT; one shared timer of width $clog2(max(REPEAT_DELAY,REPEAT_RATE)); latched direction dir.
- IDLE:
  - enable=1 and sel != none: move_pulse <= onehot(sel), dir <= sel, timer <= 0, go to DELAY.
  - Otherwise move_pulse <= 0.
- DELAY:
  - If enable=0 or sel != dir: go to IDLE, timer cleared, no pulse.
  - Else if timer == REPEAT_DELAY-1: pulse onehot(dir), timer <= 0, go to REPEAT.
  - Else timer increments.
- REPEAT:
  - Same abort rule as DELAY.
  - timer == REPEAT_RATE-1: pulse onehot(dir), timer <= 0.
  - Otherwise timer increments.
  - repeating = 1 only in this state (registered).
- Pulse rules:
  - move_pulse is registered, high exactly one cycle per event, never more than one bit set.
  - Latency: btn_level rising → move_pulse one cycle later.
- Simultaneous or overlapping presses:
  - A higher-priority button pressed while a lower one is held aborts to IDLE.
  - IDLE then pulses the new direction on the following decision cycle, so there is a 1-cycle gap.
  - Releasing the higher button while the lower is still held behaves the same way for the lower direction.
- enable:
  - Deasserting enable aborts to IDLE within one cycle; debouncing continues.
  - Reasserting enable while a button is held pulses immediately from IDLE.
- Reset mid-operation: immediate clear, no pulse on reset release until a fresh debounced press.
- Arithmetic: counters saturate-free because they clear at terminal count; no wrap-around reachable.

Test Plan:
All scenarios use parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5.
- Clean press up, held 3 cycles of rst=1 idle first → btn_level[0]=1 exactly 2+4 cycles after btns[0] rises; move_pulse=4'b0001 for one cycle on the next cycle.
- 3-cycle glitch on btns[2] → btn_level and move_pulse remain 0 throughout.
- Hold right for 40 cycles → first pulse 4'b1000, second pulse 10 cycles later with repeating=1, then pulses every 5 cycles; release → pulses stop, repeating=0 after debounce.
- Hold left, then press up during DELAY → left pulse, abort, up pulse 4'b0001 two cycles after btn_level[0] rises; never two bits set.
- enable=0 while holding down → no pulses; raise enable → pulse 4'b0010 next cycle, repeat timing restarts from 0.
- Assert rst=0 asynchronously between clock edges during REPEAT → all outputs 0 immediately; after release with button still held, first pulse occurs only after the full 2+4-cycle sync/debounce latency.
